// File: rtl/rp2040_interface.sv
// -----------------------------------------------------------------------------
// rp2040_interface
//
// SPI slave control/status register file between the RP2040 MCU and the SDR
// datapath. The MCU writes tuning, gain, filter and dynamic-reconfiguration
// registers. It reads back those registers, the live datapath status word and
// a fixed device ID. The stored register values drive static control outputs.
//
// Frame format (spi_cs_n low, counted in spi_clk rising edges):
//   edge 1       lead-in, MOSI ignored
//   edges 2-9    8-bit command, MSB first (bit7: 1=read, bits[6:0]=address)
//   edges 10-41  32 data bits, MSB first
//   edges > 41   ignored until spi_cs_n returns high
//
// Ports:
//   spi_clk          in   sole clock, rising edge
//   rst              in   synchronous active-high reset
//   spi_cs_n         in   frame select, active low
//   spi_mosi         in   serial data in
//   spi_miso         out  serial read data
//   frequency_word   out  reg 0x00
//   gain_control     out  reg 0x01
//   filter_select    out  reg 0x02[3:0]
//   enable_control   out  reg 0x03[0]
//   streaming_mode   out  reg 0x03[1]
//   bandwidth_limit  out  reg 0x04 (resets to 8'hFF)
//   processing_mode  out  reg 0x20[2:0]
//   modulation_type  out  reg 0x21
//   filter_bandwidth out  reg 0x22
//   clock_gating_en  out  reg 0x23[0]
//   thermal_scaling  out  reg 0x24
//   resource_opt_en  out  reg 0x25[0]
//   power_profile    out  reg 0x26
//   status_reg       in   read via 0x30[15:0]
//   pll_locked       in   read via 0x30[16]
//   eth_link_status  in   read via 0x30[17]
//
// DATA_WIDTH must be 32; the frame timing is built around a 32-bit payload.
// -----------------------------------------------------------------------------
module rp2040_interface #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] DEVICE_ID  = 32'h52503230
) (
  input  logic        spi_clk,
  input  logic        rst,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [31:0] frequency_word,
  output logic [7:0]  gain_control,
  output logic [3:0]  filter_select,
  output logic        enable_control,
  output logic        streaming_mode,
  output logic [7:0]  bandwidth_limit,
  output logic [2:0]  processing_mode,
  output logic [7:0]  modulation_type,
  output logic [7:0]  filter_bandwidth,
  output logic        clock_gating_en,
  output logic [7:0]  thermal_scaling,
  output logic        resource_opt_en,
  output logic [7:0]  power_profile,
  input  logic [15:0] status_reg,
  input  logic        pll_locked,
  input  logic        eth_link_status
);

  localparam logic [6:0] ADDR_FREQ    = 7'h00;
  localparam logic [6:0] ADDR_GAIN    = 7'h01;
  localparam logic [6:0] ADDR_FILTER  = 7'h02;
  localparam logic [6:0] ADDR_CTRL    = 7'h03;
  localparam logic [6:0] ADDR_BW      = 7'h04;
  localparam logic [6:0] ADDR_PMODE   = 7'h20;
  localparam logic [6:0] ADDR_MOD     = 7'h21;
  localparam logic [6:0] ADDR_FBW     = 7'h22;
  localparam logic [6:0] ADDR_CGATE   = 7'h23;
  localparam logic [6:0] ADDR_THERM   = 7'h24;
  localparam logic [6:0] ADDR_RESOPT  = 7'h25;
  localparam logic [6:0] ADDR_POWER   = 7'h26;
  localparam logic [6:0] ADDR_STATUS  = 7'h30;
  localparam logic [6:0] ADDR_ID      = 7'h3F;

  // Edge counter saturates one past the last data edge so that any further
  // edges in the same frame fall outside every decode window.
  localparam logic [5:0] EDGE_SAT     = 6'd42;

  // Frame state
  logic [5:0]            edge_cnt_reg;
  logic [7:0]            cmd_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] rd_shift_reg;

  // Register storage
  logic [31:0] freq_reg;
  logic [7:0]  gain_reg;
  logic [3:0]  filter_reg;
  logic        enable_reg;
  logic        stream_reg;
  logic [7:0]  bw_reg;
  logic [2:0]  pmode_reg;
  logic [7:0]  mod_reg;
  logic [7:0]  fbw_reg;
  logic        cgate_reg;
  logic [7:0]  therm_reg;
  logic        resopt_reg;
  logic [7:0]  power_reg;

  // Number of the edge currently being taken (1-based within the frame),
  // and the command/data words including the bit arriving on this edge.
  logic [5:0]            edge_num;
  logic [7:0]            cmd_next;
  logic [DATA_WIDTH-1:0] data_next;
  logic                  commit;
  logic [31:0]           read_value;

  assign edge_num  = edge_cnt_reg + 6'd1;
  assign cmd_next  = {cmd_reg[6:0], spi_mosi};
  assign data_next = {data_reg[DATA_WIDTH-2:0], spi_mosi};
  // Command is complete and frozen by edge 41, so cmd_reg is safe to use here.
  assign commit    = !spi_cs_n && (edge_num == 6'd41) && !cmd_reg[7];

  // Read mux, addressed by the command as it completes on edge 9.
  always_comb begin
    read_value = 32'h0;
    case (cmd_next[6:0])
      ADDR_FREQ:   read_value = freq_reg;
      ADDR_GAIN:   read_value = {24'h0, gain_reg};
      ADDR_FILTER: read_value = {28'h0, filter_reg};
      ADDR_CTRL:   read_value = {30'h0, stream_reg, enable_reg};
      ADDR_BW:     read_value = {24'h0, bw_reg};
      ADDR_PMODE:  read_value = {29'h0, pmode_reg};
      ADDR_MOD:    read_value = {24'h0, mod_reg};
      ADDR_FBW:    read_value = {24'h0, fbw_reg};
      ADDR_CGATE:  read_value = {31'h0, cgate_reg};
      ADDR_THERM:  read_value = {24'h0, therm_reg};
      ADDR_RESOPT: read_value = {31'h0, resopt_reg};
      ADDR_POWER:  read_value = {24'h0, power_reg};
      ADDR_STATUS: read_value = {14'h0, eth_link_status, pll_locked, status_reg};
      ADDR_ID:     read_value = DEVICE_ID;
      default:     read_value = 32'h0;
    endcase
  end

  // Frame sequencing and read shifter
  always_ff @(posedge spi_clk) begin
    if (rst) begin
      edge_cnt_reg <= 6'd0;
      cmd_reg      <= 8'h0;
      data_reg     <= '0;
      rd_shift_reg <= '0;
    end else if (spi_cs_n) begin
      edge_cnt_reg <= 6'd0;
      rd_shift_reg <= '0;
    end else begin
      if (edge_cnt_reg != EDGE_SAT) begin
        edge_cnt_reg <= edge_num;
      end
      if (edge_num >= 6'd2 && edge_num <= 6'd9) begin
        cmd_reg <= cmd_next;
      end
      if (edge_num >= 6'd10 && edge_num <= 6'd41) begin
        data_reg <= data_next;
      end
      // The shifter is only ever loaded by reads, so it stays zero (and
      // MISO stays low) throughout write frames.
      if (edge_num == 6'd9 && cmd_next[7]) begin
        rd_shift_reg <= read_value;
      end else if (edge_num >= 6'd10 && edge_num <= 6'd40) begin
        rd_shift_reg <= {rd_shift_reg[DATA_WIDTH-2:0], 1'b0};
      end else if (edge_num == 6'd41) begin
        rd_shift_reg <= '0;
      end
    end
  end

  // Register writes; reset takes priority over a commit on the same edge.
  always_ff @(posedge spi_clk) begin
    if (rst) begin
      freq_reg   <= 32'h0;
      gain_reg   <= 8'h0;
      filter_reg <= 4'h0;
      enable_reg <= 1'b0;
      stream_reg <= 1'b0;
      bw_reg     <= 8'hFF;
      pmode_reg  <= 3'h0;
      mod_reg    <= 8'h0;
      fbw_reg    <= 8'h0;
      cgate_reg  <= 1'b0;
      therm_reg  <= 8'h0;
      resopt_reg <= 1'b0;
      power_reg  <= 8'h0;
    end else if (commit) begin
      case (cmd_reg[6:0])
        ADDR_FREQ:   freq_reg   <= data_next[31:0];
        ADDR_GAIN:   gain_reg   <= data_next[7:0];
        ADDR_FILTER: filter_reg <= data_next[3:0];
        ADDR_CTRL: begin
          enable_reg <= data_next[0];
          stream_reg <= data_next[1];
        end
        ADDR_BW:     bw_reg     <= data_next[7:0];
        ADDR_PMODE:  pmode_reg  <= data_next[2:0];
        ADDR_MOD:    mod_reg    <= data_next[7:0];
        ADDR_FBW:    fbw_reg    <= data_next[7:0];
        ADDR_CGATE:  cgate_reg  <= data_next[0];
        ADDR_THERM:  therm_reg  <= data_next[7:0];
        ADDR_RESOPT: resopt_reg <= data_next[0];
        ADDR_POWER:  power_reg  <= data_next[7:0];
        default: ; // status, ID and unmapped addresses are read-only / ignored
      endcase
    end
  end

  assign spi_miso         = rd_shift_reg[DATA_WIDTH-1];
  assign frequency_word   = freq_reg;
  assign gain_control     = gain_reg;
  assign filter_select    = filter_reg;
  assign enable_control   = enable_reg;
  assign streaming_mode   = stream_reg;
  assign bandwidth_limit  = bw_reg;
  assign processing_mode  = pmode_reg;
  assign modulation_type  = mod_reg;
  assign filter_bandwidth = fbw_reg;
  assign clock_gating_en  = cgate_reg;
  assign thermal_scaling  = therm_reg;
  assign resource_opt_en  = resopt_reg;
  assign power_profile    = power_reg;

endmodule

// File: tb/tb_rp2040_interface.sv
// -----------------------------------------------------------------------------
// tb_rp2040_interface
//
// Directed bench for rp2040_interface. Drives SPI frames edge by edge on the
// falling edge of spi_clk, samples outputs on the falling edge, and compares
// against hand-computed values with immediate assertions.
// -----------------------------------------------------------------------------
module tb_rp2040_interface;

  logic        spi_clk;
  logic        rst;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic [31:0] frequency_word;
  logic [7:0]  gain_control;
  logic [3:0]  filter_select;
  logic        enable_control;
  logic        streaming_mode;
  logic [7:0]  bandwidth_limit;
  logic [2:0]  processing_mode;
  logic [7:0]  modulation_type;
  logic [7:0]  filter_bandwidth;
  logic        clock_gating_en;
  logic [7:0]  thermal_scaling;
  logic        resource_opt_en;
  logic [7:0]  power_profile;
  logic [15:0] status_reg;
  logic        pll_locked;
  logic        eth_link_status;

  int checks = 0;
  int errors = 0;

  logic [31:0] rdata;
  logic        miso_seen;
  logic        miso_after;
  logic [31:0] fw_at_41;

  rp2040_interface #(
    .DATA_WIDTH (32),
    .DEVICE_ID  (32'h52503230)
  ) dut (
    .spi_clk          (spi_clk),
    .rst              (rst),
    .spi_cs_n         (spi_cs_n),
    .spi_mosi         (spi_mosi),
    .spi_miso         (spi_miso),
    .frequency_word   (frequency_word),
    .gain_control     (gain_control),
    .filter_select    (filter_select),
    .enable_control   (enable_control),
    .streaming_mode   (streaming_mode),
    .bandwidth_limit  (bandwidth_limit),
    .processing_mode  (processing_mode),
    .modulation_type  (modulation_type),
    .filter_bandwidth (filter_bandwidth),
    .clock_gating_en  (clock_gating_en),
    .thermal_scaling  (thermal_scaling),
    .resource_opt_en  (resource_opt_en),
    .power_profile    (power_profile),
    .status_reg       (status_reg),
    .pll_locked       (pll_locked),
    .eth_link_status  (eth_link_status)
  );

  initial spi_clk = 1'b0;
  always #5 spi_clk = ~spi_clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
    $display("check %-22s observed=%h expected=%h", tag, observed, expected);
  endtask

  // One SPI frame of nedges edges with cs_n low, followed by one edge with
  // cs_n high. Called and returning at a falling edge. rst is pulsed around
  // edge rst_edge (0 = never). MISO bits are captured after edges 9..40.
  task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] data,
                           input int nedges, input int rst_edge,
                           output logic [31:0] rd, output logic seen,
                           output logic after41);
    rd      = 32'h0;
    seen    = 1'b0;
    after41 = 1'b0;
    spi_cs_n = 1'b0;
    for (int k = 1; k <= nedges; k++) begin
      if (k == 1)       spi_mosi = 1'b0;
      else if (k <= 9)  spi_mosi = cmd[9 - k];
      else if (k <= 41) spi_mosi = data[41 - k];
      else              spi_mosi = 1'b1;
      rst = (k == rst_edge);
      @(posedge spi_clk);
      @(negedge spi_clk);
      rst = 1'b0;
      seen = seen | spi_miso;
      if (k >= 9 && k <= 40) rd[40 - k] = spi_miso;
      if (k == 41) begin
        after41  = spi_miso;
        fw_at_41 = frequency_word;
      end
    end
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    @(posedge spi_clk);
    @(negedge spi_clk);
    $display("frame cmd=%h data=%h edges=%0d rd=%h", cmd, data, nedges, rd);
  endtask

  initial begin
    rst             = 1'b1;
    spi_cs_n        = 1'b1;
    spi_mosi        = 1'b0;
    status_reg      = 16'h0;
    pll_locked      = 1'b0;
    eth_link_status = 1'b0;
    fw_at_41        = 32'h0;
    repeat (3) @(negedge spi_clk);
    rst = 1'b0;
    @(negedge spi_clk);

    // Reset state
    check("rst_freq", frequency_word, 32'h0);
    check("rst_bw", {24'h0, bandwidth_limit}, 32'hFF);
    check("rst_miso", {31'h0, spi_miso}, 32'h0);
    check("rst_misc", {gain_control, filter_select, enable_control, streaming_mode,
                       processing_mode, modulation_type, 3'b0},
          32'h0);
    check("rst_misc2", {filter_bandwidth, thermal_scaling, power_profile,
                        5'b0, clock_gating_en, resource_opt_en, 1'b0},
          32'h0);

    // Write 0x00; new value visible right after edge 41
    spi_frame(8'h00, 32'h12345678, 41, 0, rdata, miso_seen, miso_after);
    check("wr00_at_edge41", fw_at_41, 32'h12345678);
    check("wr00_freq", frequency_word, 32'h12345678);
    check("wr00_gain_same", {24'h0, gain_control}, 32'h0);
    check("wr00_bw_same", {24'h0, bandwidth_limit}, 32'hFF);
    check("wr00_miso_quiet", {31'h0, miso_seen}, 32'h0);

    // processing_mode stores only 3 bits
    spi_frame(8'h20, 32'h00000002, 41, 0, rdata, miso_seen, miso_after);
    check("wr20_pmode2", {29'h0, processing_mode}, 32'h2);
    spi_frame(8'h20, 32'hFFFFFFFF, 41, 0, rdata, miso_seen, miso_after);
    check("wr20_pmode7", {29'h0, processing_mode}, 32'h7);

    spi_frame(8'h01, 32'h0000007F, 41, 0, rdata, miso_seen, miso_after);
    spi_frame(8'h21, 32'h00000001, 41, 0, rdata, miso_seen, miso_after);
    spi_frame(8'h23, 32'h00000001, 41, 0, rdata, miso_seen, miso_after);
    check("wr01_gain", {24'h0, gain_control}, 32'h7F);
    check("wr21_mod", {24'h0, modulation_type}, 32'h01);
    check("wr23_cgate", {31'h0, clock_gating_en}, 32'h1);

    spi_frame(8'h02, 32'hFFFFFFF5, 41, 0, rdata, miso_seen, miso_after);
    check("wr02_filter", {28'h0, filter_select}, 32'h5);
    spi_frame(8'h03, 32'h00000003, 41, 0, rdata, miso_seen, miso_after);
    check("wr03_en_stream", {30'h0, streaming_mode, enable_control}, 32'h3);

    // Frame longer than 41 edges: trailing ones ignored
    spi_frame(8'h04, 32'h00000012, 45, 0, rdata, miso_seen, miso_after);
    check("wr04_long_frame", {24'h0, bandwidth_limit}, 32'h12);

    // Read-back of writable registers (unused bits read 0)
    spi_frame(8'h80, 32'h0, 41, 0, rdata, miso_seen, miso_after);
    check("rd00", rdata, 32'h12345678);
    check("rd00_miso_after41", {31'h0, miso_after}, 32'h0);
    spi_frame(8'hA0, 32'h0, 41, 0, rdata, miso_seen, miso_after);
    check("rd20", rdata, 32'h00000007);
    spi_frame(8'h82, 32'h0, 41, 0, rdata, miso_seen, miso_after);
    check("rd02", rdata, 32'h00000005);
    spi_frame(8'h84, 32'h0, 41, 0, rdata, miso_seen, miso_after);
    check("rd04", rdata, 32'h00000012);

    // Status and ID reads
    status_reg      = 16'hABCD;
    pll_locked      = 1'b1;
    eth_link_status = 1'b1;
    spi_frame(8'hB0, 32'h0, 41, 0, rdata, miso_seen, miso_after);
    check("rd30_status", rdata, 32'h0003ABCD);
    spi_frame(8'hBF, 32'h0, 41, 0, rdata, miso_seen, miso_after);
    check("rd3f_id", rdata, 32'h52503230);
    spi_frame(8'h3F, 32'h11111111, 41, 0, rdata, miso_seen, miso_after);
    spi_frame(8'hBF, 32'h0, 41, 0, rdata, miso_seen, miso_after);
    check("rd3f_after_wr", rdata, 32'h52503230);

    // Aborted write leaves register unchanged; next full frame works
    spi_frame(8'h00, 32'hDEADBEEF, 20, 0, rdata, miso_seen, miso_after);
    check("abort_freq", frequency_word, 32'h12345678);
    spi_frame(8'h00, 32'hCAFEF00D, 41, 0, rdata, miso_seen, miso_after);
    check("after_abort_freq", frequency_word, 32'hCAFEF00D);

    // Reset restores defaults
    rst = 1'b1;
    @(negedge spi_clk);
    rst = 1'b0;
    check("rst2_freq", frequency_word, 32'h0);
    check("rst2_bw", {24'h0, bandwidth_limit}, 32'hFF);
    check("rst2_misc", {gain_control, modulation_type, 5'b0, processing_mode,
                        clock_gating_en, filter_select, 3'b0},
          32'h0);

    // Unmapped address
    spi_frame(8'h7E, 32'hFFFFFFFF, 41, 0, rdata, miso_seen, miso_after);
    spi_frame(8'hFE, 32'h0, 41, 0, rdata, miso_seen, miso_after);
    check("rd7e_unmapped", rdata, 32'h0);

    // rst on the commit edge wins over the write
    spi_frame(8'h00, 32'h0BADF00D, 41, 41, rdata, miso_seen, miso_after);
    check("rst_vs_commit", frequency_word, 32'h0);
    spi_frame(8'h00, 32'h00C0FFEE, 41, 0, rdata, miso_seen, miso_after);
    check("wr_after_rst", frequency_word, 32'h00C0FFEE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
